dcache_tag_bank: RTL and testbench

// - Parametrised N-way tag store for the data cache; successor to the single-way 16x24 tag macro model.
// - Holds per-way tag, valid and dirty bits for every set on one RW port with the macro's timing: inputs registered, read combinational from the registered address.
// - Adds a per-way write mask, asynchronous flash-clear of valid/dirty on reset and a sequential full-cache invalidate sweep (flush).

---
 rtl/dcache_tag_bank_pkg.sv | 26 ++
 rtl/dcache_tag_bank_flush_ctrl.sv | 54 +++++
 rtl/dcache_tag_bank.sv | 136 +++++++++++++
 tb/tb_dcache_tag_bank.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_tag_bank_pkg.sv
// Shared types and geometry for the data-cache tag bank.
// The parity field of way_meta_t exists only when DCACHE_TAG_PARITY_EN is defined.
package dcache_pkg;

    localparam int TAG_WIDTH = 23;
    localparam int SET_BITS  = 4;
    localparam int NUM_WAYS  = 4;
    localparam int DEPTH     = 1 << SET_BITS;

    typedef logic [TAG_WIDTH-1:0] tag_t;
    typedef logic [SET_BITS-1:0]  set_idx_t;

    typedef struct packed {
        logic valid;
        logic dirty;
`ifdef DCACHE_TAG_PARITY_EN
        logic parity;
`endif
    } way_meta_t;

    typedef enum logic [0:0] {
        FL_IDLE  = 1'b0,
        FL_SWEEP = 1'b1
    } flush_state_t;

endpackage

// File: rtl/dcache_tag_bank_flush_ctrl.sv
// Flush sequencer: walks every set once, issuing one clear strobe per cycle,
// and reports busy for exactly DEPTH cycles after the request is accepted.
module dcache_flush_ctrl
    import dcache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_req_i,
    output logic                idle_o,
    output logic                busy_o,
    output logic                clr_o,
    output logic [SET_BITS-1:0] clr_idx_o
);

    flush_state_t state_q;
    set_idx_t     ctr_q;
    logic         busy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FL_IDLE;
            ctr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                FL_IDLE: begin
                    if (flush_req_i) begin
                        state_q <= FL_SWEEP;
                        ctr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FL_SWEEP: begin
                    // The counter wraps back to zero on the final set.
                    ctr_q <= ctr_q + 1'b1;
                    if (ctr_q == set_idx_t'(DEPTH - 1)) begin
                        state_q <= FL_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FL_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign idle_o    = (state_q == FL_IDLE);
    assign busy_o    = busy_q;
    assign clr_o     = (state_q == FL_SWEEP);
    assign clr_idx_o = ctr_q;

endmodule

// File: rtl/dcache_tag_bank.sv
// N-way data-cache tag store: registered-input single RW port, combinational read of the
// registered set, per-way write mask, async valid/dirty clear and flush sweep.
// Optional per-way even parity and parity_err0 output under DCACHE_TAG_PARITY_EN.
module dcache_tag_bank
    import dcache_pkg::*;
(
    input  logic                          clk0,
    input  logic                          rst0,
    input  logic                          csb0,
    input  logic                          web0,
    input  logic [NUM_WAYS-1:0]           wmask0,
    input  logic [SET_BITS-1:0]           addr0,
    input  logic [TAG_WIDTH-1:0]          din0_tag,
    input  logic                          din0_valid,
    input  logic                          din0_dirty,
    output logic [NUM_WAYS*TAG_WIDTH-1:0] dout0_tag,
    output logic [NUM_WAYS-1:0]           dout0_valid,
    output logic [NUM_WAYS-1:0]           dout0_dirty,
    input  logic                          flush_req,
    output logic                          flush_busy
`ifdef DCACHE_TAG_PARITY_EN
    ,
    output logic [NUM_WAYS-1:0]           parity_err0
`endif
);

    logic     fl_idle;
    logic     clr_en;
    set_idx_t clr_idx;
    logic     access_en;

    dcache_flush_ctrl u_flush_ctrl (
        .clk_i       (clk0),
        .rst_i       (rst0),
        .flush_req_i (flush_req),
        .idle_o      (fl_idle),
        .busy_o      (flush_busy),
        .clr_o       (clr_en),
        .clr_idx_o   (clr_idx)
    );

    // An access coinciding with a flush request is dropped outright.
    assign access_en = !csb0 && fl_idle && !flush_req;

    logic                web_q;
    set_idx_t            addr_q;
    logic [NUM_WAYS-1:0] wmask_q;
    tag_t                din_tag_q;
    logic                din_valid_q;
    logic                din_dirty_q;
`ifdef DCACHE_TAG_PARITY_EN
    logic                din_parity_q;
`endif

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            web_q  <= 1'b1;
            addr_q <= '0;
        end else if (access_en) begin
            web_q  <= web0;
            addr_q <= addr0;
        end else begin
            web_q  <= 1'b1;
        end
    end

    // Write payload is only consumed while web_q is low, so it needs no reset.
    always_ff @(posedge clk0) begin
        if (access_en) begin
            wmask_q     <= wmask0;
            din_tag_q   <= din0_tag;
            din_valid_q <= din0_valid;
            din_dirty_q <= din0_dirty;
`ifdef DCACHE_TAG_PARITY_EN
            din_parity_q <= ^{din0_tag, din0_valid, din0_dirty};
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            tag_t             tag_mem_q [DEPTH];
            logic [DEPTH-1:0] valid_q;
            logic [DEPTH-1:0] dirty_q;
`ifdef DCACHE_TAG_PARITY_EN
            logic [DEPTH-1:0] parity_q;
`endif
            logic             way_we;
            way_meta_t        rd_meta;

            assign way_we = !web_q && wmask_q[gi];

            always_ff @(posedge clk0) begin
                if (way_we) begin
                    tag_mem_q[addr_q] <= din_tag_q;
                end
            end

            // Writes are never captured during a sweep, so the clear and write paths never collide.
            always_ff @(posedge clk0 or posedge rst0) begin
                if (rst0) begin
                    valid_q <= '0;
                    dirty_q <= '0;
`ifdef DCACHE_TAG_PARITY_EN
                    parity_q <= '0;
`endif
                end else if (clr_en) begin
                    valid_q[clr_idx] <= 1'b0;
                    dirty_q[clr_idx] <= 1'b0;
`ifdef DCACHE_TAG_PARITY_EN
                    parity_q[clr_idx] <= 1'b0;
`endif
                end else if (way_we) begin
                    valid_q[addr_q] <= din_valid_q;
                    dirty_q[addr_q] <= din_dirty_q;
`ifdef DCACHE_TAG_PARITY_EN
                    parity_q[addr_q] <= din_parity_q;
`endif
                end
            end

            assign rd_meta.valid = valid_q[addr_q];
            assign rd_meta.dirty = dirty_q[addr_q];
`ifdef DCACHE_TAG_PARITY_EN
            assign rd_meta.parity = parity_q[addr_q];
            assign parity_err0[gi] = (^{tag_mem_q[addr_q], rd_meta.valid, rd_meta.dirty}) ^ rd_meta.parity;
`endif

            assign dout0_tag[gi*TAG_WIDTH +: TAG_WIDTH] = tag_mem_q[addr_q];
            assign dout0_valid[gi] = rd_meta.valid;
            assign dout0_dirty[gi] = rd_meta.dirty;
        end
    endgenerate

endmodule

// File: tb/tb_dcache_tag_bank.sv
// Scoreboard bench for dcache_tag_bank: a reference model predicts each captured access,
// the prediction is queued at drive time and compared when the read data appears.
module tb_dcache_tag_bank;
    import dcache_pkg::*;

    logic                          clk0 = 1'b0;
    logic                          rst0;
    logic                          csb0;
    logic                          web0;
    logic [NUM_WAYS-1:0]           wmask0;
    logic [SET_BITS-1:0]           addr0;
    logic [TAG_WIDTH-1:0]          din0_tag;
    logic                          din0_valid;
    logic                          din0_dirty;
    logic [NUM_WAYS*TAG_WIDTH-1:0] dout0_tag;
    logic [NUM_WAYS-1:0]           dout0_valid;
    logic [NUM_WAYS-1:0]           dout0_dirty;
    logic                          flush_req;
    logic                          flush_busy;
`ifdef DCACHE_TAG_PARITY_EN
    logic [NUM_WAYS-1:0]           parity_err0;
`endif

    dcache_tag_bank dut (
        .clk0        (clk0),
        .rst0        (rst0),
        .csb0        (csb0),
        .web0        (web0),
        .wmask0      (wmask0),
        .addr0       (addr0),
        .din0_tag    (din0_tag),
        .din0_valid  (din0_valid),
        .din0_dirty  (din0_dirty),
        .dout0_tag   (dout0_tag),
        .dout0_valid (dout0_valid),
        .dout0_dirty (dout0_dirty),
        .flush_req   (flush_req),
        .flush_busy  (flush_busy)
`ifdef DCACHE_TAG_PARITY_EN
        ,
        .parity_err0 (parity_err0)
`endif
    );

    always #5 clk0 = ~clk0;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s value=%0h", tag, obs);
        end
    endtask

    typedef struct {
        int                            set;
        logic [NUM_WAYS-1:0]           v;
        logic [NUM_WAYS-1:0]           d;
        logic [NUM_WAYS*TAG_WIDTH-1:0] tag;
        logic [NUM_WAYS*TAG_WIDTH-1:0] tmask;
    } exp_t;

    exp_t sb_q[$];

    // Reference model of the array contents and the port pipeline.
    logic [NUM_WAYS-1:0]  m_v     [DEPTH];
    logic [NUM_WAYS-1:0]  m_d     [DEPTH];
    logic [NUM_WAYS-1:0]  m_known [DEPTH];
    logic [TAG_WIDTH-1:0] m_tag   [DEPTH][NUM_WAYS];
    bit                   p_we;
    int                   p_set;
    logic [NUM_WAYS-1:0]  p_mask;
    logic [TAG_WIDTH-1:0] p_tag;
    bit                   p_v, p_d;
    int                   m_busy;
    int                   m_addrq;

    task automatic model_reset();
        for (int s = 0; s < DEPTH; s++) begin
            m_v[s] = '0;
            m_d[s] = '0;
        end
        p_we    = 0;
        m_busy  = 0;
        m_addrq = 0;
    endtask

    // Called at a negedge; drives one cycle of stimulus and returns at the next negedge.
    task automatic do_op(input bit cs_n, input bit we_n, input logic [NUM_WAYS-1:0] mask,
                         input int set, input logic [TAG_WIDTH-1:0] tag,
                         input bit v, input bit d, input bit fl);
        bit   cap;
        exp_t e;
        csb0       = cs_n;
        web0       = we_n;
        wmask0     = mask;
        addr0      = set[SET_BITS-1:0];
        din0_tag   = tag;
        din0_valid = v;
        din0_dirty = d;
        flush_req  = fl;
        cap = !cs_n && (m_busy == 0) && !fl;
        if (p_we) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (p_mask[w]) begin
                    m_tag[p_set][w]   = p_tag;
                    m_known[p_set][w] = 1'b1;
                    m_v[p_set][w]     = p_v;
                    m_d[p_set][w]     = p_d;
                end
            end
            p_we = 0;
        end
        if (m_busy > 0) begin
            m_v[DEPTH - m_busy] = '0;
            m_d[DEPTH - m_busy] = '0;
            m_busy--;
        end else if (fl) begin
            m_busy = DEPTH;
        end
        if (cap) begin
            m_addrq = set;
            e.set   = set;
            e.v     = m_v[set];
            e.d     = m_d[set];
            for (int w = 0; w < NUM_WAYS; w++) begin
                e.tmask[w*TAG_WIDTH +: TAG_WIDTH] = m_known[set][w] ? {TAG_WIDTH{1'b1}} : '0;
                e.tag[w*TAG_WIDTH +: TAG_WIDTH]   = m_known[set][w] ? m_tag[set][w] : '0;
            end
            sb_q.push_back(e);
            if (!we_n) begin
                p_we = 1; p_set = set; p_mask = mask; p_tag = tag; p_v = v; p_d = d;
            end
        end
        @(posedge clk0);
        @(negedge clk0);
        if (cap) begin
            if (sb_q.size() == 0) begin
                check_eq("scoreboard_empty", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_eq($sformatf("set%0d_valid", e.set), dout0_valid, e.v);
                check_eq($sformatf("set%0d_dirty", e.set), dout0_dirty, e.d);
                if (e.tmask != '0)
                    check_eq($sformatf("set%0d_tag", e.set), dout0_tag & e.tmask, e.tag);
            end
        end
    endtask

    function automatic logic [TAG_WIDTH-1:0] fill_tag(input int s);
        return TAG_WIDTH'(32'h0A5000 + s * 32'h111);
    endfunction

    int busy_cnt;

    initial begin
        for (int s = 0; s < DEPTH; s++) m_known[s] = '0;
        model_reset();
        rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0;
        din0_tag = '0; din0_valid = 1'b0; din0_dirty = 1'b0; flush_req = 1'b0;
        @(negedge clk0);
        @(negedge clk0);
        rst0 = 1'b0;
        check_eq("reset_valid", dout0_valid, 0);
        check_eq("reset_dirty", dout0_dirty, 0);
        check_eq("reset_busy", flush_busy, 0);

        for (int s = 0; s < DEPTH; s++) do_op(0, 1, '0, s, '0, 0, 0, 0);

        // Single-way write, then read back.
        do_op(0, 0, 4'b0100, 5, 23'h1ABCDE, 1, 1, 0);
        do_op(0, 1, '0, 5, '0, 0, 0, 0);

        // Back-to-back write and read of the same set: old data first, new data after commit.
        do_op(0, 0, 4'b0011, 3, 23'h012345, 1, 0, 0);
        do_op(0, 1, '0, 3, '0, 0, 0, 0);

        for (int i = 0; i < 24; i++)
            do_op(0, $urandom_range(0, 1), NUM_WAYS'($urandom), $urandom_range(0, DEPTH - 1),
                  TAG_WIDTH'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), 0);

        // Fill everything valid, then flush with a concurrent write to set 7.
        for (int s = 0; s < DEPTH; s++) do_op(0, 0, 4'hF, s, fill_tag(s), 1, 1, 0);
        do_op(0, 0, 4'hF, 7, 23'h7FFFFF, 1, 1, 1);
        busy_cnt = 0;
        for (int i = 0; i < 40 && flush_busy; i++) begin
            busy_cnt++;
            check_eq($sformatf("sweep_track_%0d", i), dout0_valid, m_v[m_addrq]);
            do_op(0, 0, 4'hF, 7, 23'h7FFFFF, 1, 1, 0);
        end
        check_eq("flush_busy_cycles", busy_cnt, DEPTH);
        check_eq("post_flush_track", dout0_valid, 0);
        for (int s = 0; s < DEPTH; s++) do_op(0, 1, '0, s, '0, 0, 0, 0);

        // Reset in the middle of a second sweep.
        for (int s = 0; s < DEPTH; s++) do_op(0, 0, 4'hF, s, fill_tag(s) ^ 23'h400000, 1, 1, 0);
        do_op(1, 1, '0, 0, '0, 0, 0, 1);
        for (int i = 0; i < 6; i++) do_op(1, 1, '0, 0, '0, 0, 0, 0);
        check_eq("busy_before_rst", flush_busy, 1);
        csb0 = 1'b1;
        flush_req = 1'b0;
        rst0 = 1'b1;
        #1;
        check_eq("midsweep_rst_busy", flush_busy, 0);
        check_eq("midsweep_rst_valid", dout0_valid, 0);
        check_eq("midsweep_rst_dirty", dout0_dirty, 0);
        model_reset();
        @(negedge clk0);
        rst0 = 1'b0;
        for (int s = 0; s < DEPTH; s++) do_op(0, 1, '0, s, '0, 0, 0, 0);
        do_op(0, 0, 4'b1001, 2, 23'h055AA5, 1, 0, 0);
        do_op(0, 1, '0, 2, '0, 0, 0, 0);

`ifdef DCACHE_TAG_PARITY_EN
        do_op(0, 0, 4'hF, 9, 23'h0F0F0F, 1, 0, 0);
        do_op(0, 1, '0, 9, '0, 0, 0, 0);
        check_eq("parity_clean", parity_err0, 4'b0000);
        dut.g_way[1].tag_mem_q[9][0] = ~dut.g_way[1].tag_mem_q[9][0];
        m_tag[9][1][0] = ~m_tag[9][1][0];
        do_op(0, 1, '0, 9, '0, 0, 0, 0);
        check_eq("parity_flip", parity_err0, 4'b0010);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
